// File: rtl/mrd_sink_wr_np_pkg.sv
// Shared definitions for the mixed-radix memory sink write stage.
// FSM encoding, width helper and complex sample type.
package mrd_sink_wr_np_pkg;

  localparam logic [2:0] IDLE        = 3'd0;
  localparam logic [2:0] SINK        = 3'd1;
  localparam logic [2:0] WAIT_TO_RD  = 3'd2;
  localparam logic [2:0] RD          = 3'd3;
  localparam logic [2:0] WAIT_WR_END = 3'd4;
  localparam logic [2:0] SOURCE      = 3'd5;

  // ceil(log2(n)), never below 1 so a 1-entry range still has a bit
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  typedef struct packed {
    logic [15:0] re;
    logic [15:0] im;
  } cplx16_t;

endpackage

// File: rtl/mrd_sink_wr_np_if.sv
// Sink beat input and per-bank RAM write port bundle.
// master drives beats, slave is the write stage.
interface mrd_sink_wr_np_if #(
  parameter int P     = 4,
  parameter int NBANK = 7,
  parameter int wADDR = 8,
  parameter int wDATA = 16,
  parameter int wCNT  = 12
);
  logic [wCNT-1:0]              frame_len;
  logic                         in_valid;
  logic [P-1:0][wDATA-1:0]      in_real;
  logic [P-1:0][wDATA-1:0]      in_imag;
  logic [NBANK-1:0]             wren;
  logic [NBANK-1:0][wADDR-1:0]  wraddr;
  logic [NBANK-1:0][wDATA-1:0]  din_real;
  logic [NBANK-1:0][wDATA-1:0]  din_imag;

  modport master (
    output frame_len, in_valid, in_real, in_imag,
    input  wren, wraddr, din_real, din_imag
  );

  modport slave (
    input  frame_len, in_valid, in_real, in_imag,
    output wren, wraddr, din_real, din_imag
  );
endinterface

// File: rtl/mrd_sink_wr_np_lane_ctr.sv
// Bank index / address walker for one input lane.
// Tracks g mod NBANK and g div NBANK incrementally.
module mrd_bank_lane_ctr
  import mrd_sink_wr_np_pkg::*;
#(
  parameter int P     = 4,
  parameter int NBANK = 7,
  parameter int wADDR = 8,
  parameter int LANE  = 0,
  localparam int wB   = clog2_min1(NBANK)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic [wB-1:0]    bidx,
  output logic [wADDR-1:0] adr
);

  logic [wB:0] sum;

  assign sum = {1'b0, bidx} + (wB+1)'(P);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bidx <= wB'(LANE);
      adr  <= '0;
    end else if (!in_valid) begin
      bidx <= wB'(LANE);
      adr  <= '0;
    end else if (sum >= (wB+1)'(NBANK)) begin
      bidx <= wB'(sum - (wB+1)'(NBANK));
      adr  <= adr + wADDR'(1);
    end else begin
      bidx <= sum[wB-1:0];
    end
  end

endmodule

// File: rtl/mrd_sink_wr_np.sv
// Sink write stage: scatters P lanes over NBANK RAM banks
// and produces the sink timing strobes and overtime flag.
module mrd_sink_wr_np
  import mrd_sink_wr_np_pkg::*;
#(
  parameter int P         = 4,
  parameter int NBANK     = 7,
  parameter int wADDR     = 8,
  parameter int wDATA     = 16,
  parameter int wCNT      = 12,
  parameter int TW_LEAD   = 3,
  parameter int OVT_LIMIT = 2047
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       fsm,
  mrd_sink_wr_np_if.slave  sif,
  output logic             sink_3_4,
  output logic             twdl_sop_sink,
  output logic             sink_done,
  output logic             frame_err,
  output logic             ovf,
  output logic             overTime
);

  localparam int wB  = clog2_min1(NBANK);
  localparam int wOT = clog2_min1(OVT_LIMIT + 1);

  logic [P-1:0][wB-1:0]    bidx;
  logic [P-1:0][wADDR-1:0] adr;

  for (genvar k = 0; k < P; k++) begin : g_lane
    mrd_bank_lane_ctr #(
      .P(P), .NBANK(NBANK),
      .wADDR(wADDR), .LANE(k)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (sif.in_valid),
      .bidx     (bidx[k]),
      .adr      (adr[k])
    );
  end

  logic [wCNT-1:0] len, cnt_q, cnt, thr34;
  logic            len_z, sat, wr_ok;

  // cnt is the index of the beat on the input, 0 while idle
  assign len   = sif.frame_len;
  assign len_z = (len == '0);
  assign cnt   = sif.in_valid ? cnt_q : '0;
  assign sat   = len_z ? (cnt_q == '1) : (cnt_q >= len);
  assign wr_ok = sif.in_valid & (len_z | ~sat);
  assign thr34 = (len >> 2) + (len >> 1);

  logic s34_n, tw_n, done_n, err_n, ovf_n;

  assign s34_n  = (cnt != '0) && (cnt == thr34 - wCNT'(1));
  assign tw_n   = (thr34 > wCNT'(TW_LEAD))
               && (cnt == thr34 - wCNT'(TW_LEAD));
  assign done_n = sif.in_valid && !len_z
               && (cnt == len - wCNT'(1));
  assign err_n  = !sif.in_valid && !len_z
               && (cnt_q != '0) && (cnt_q < len);
  assign ovf_n  = sif.in_valid && (ovf || (!len_z && sat));

  logic [NBANK-1:0]            wren_n;
  logic [NBANK-1:0][wADDR-1:0] addr_n;
  logic [NBANK-1:0][wDATA-1:0] re_n, im_n;

  // descending lane order lets lane 0 win any bank it shares
  always_comb begin
    wren_n = '0;
    addr_n = '0;
    re_n   = '0;
    im_n   = '0;
    for (int b = 0; b < NBANK; b++) begin
      for (int k = P - 1; k >= 0; k--) begin
        if (wr_ok && bidx[k] == wB'(b)) begin
          wren_n[b] = 1'b1;
          addr_n[b] = adr[k];
          re_n[b]   = sif.in_real[k];
          im_n[b]   = sif.in_imag[k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sif.wren      <= '0;
      sif.wraddr    <= '0;
      sif.din_real  <= '0;
      sif.din_imag  <= '0;
      cnt_q         <= '0;
      sink_3_4      <= 1'b0;
      twdl_sop_sink <= 1'b0;
      sink_done     <= 1'b0;
      frame_err     <= 1'b0;
      ovf           <= 1'b0;
    end else begin
      sif.wren      <= wren_n;
      sif.wraddr    <= addr_n;
      sif.din_real  <= re_n;
      sif.din_imag  <= im_n;
      if (!sif.in_valid) cnt_q <= '0;
      else if (!sat)     cnt_q <= cnt_q + wCNT'(1);
      sink_3_4      <= s34_n;
      twdl_sop_sink <= tw_n;
      sink_done     <= done_n;
      frame_err     <= err_n;
      ovf           <= ovf_n;
    end
  end

  logic [wOT-1:0] ot_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ot_q <= '0;
    end else if (fsm == SINK) begin
      if (ot_q != wOT'(OVT_LIMIT)) ot_q <= ot_q + wOT'(1);
    end else begin
      ot_q <= '0;
    end
  end

  assign overTime = (ot_q == wOT'(OVT_LIMIT));

endmodule

// File: tb/tb_mrd_sink_wr_np.sv
// Bench for mrd_sink_wr_np: strobe table, ramp readback,
// random bursts against a mod/div reference, P=7 and reset.
module tb_mrd_sink_wr_np;
  import mrd_sink_wr_np_pkg::*;

  localparam int P = 4, N = 7, WA = 8, WD = 16, WC = 12;
  localparam int TW = 3, OVT = 2047;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] fsm, fsm7;
  logic s34, tw, done, ferr, ovf, ot;
  logic s34_7, tw_7, done_7, ferr_7, ovf_7, ot_7;

  always #5 clk = ~clk;

  mrd_sink_wr_np_if #(.P(P), .NBANK(N), .wADDR(WA),
    .wDATA(WD), .wCNT(WC)) sif ();
  mrd_sink_wr_np_if #(.P(7), .NBANK(7), .wADDR(WA),
    .wDATA(WD), .wCNT(WC)) sif7 ();

  mrd_sink_wr_np #(.P(P), .NBANK(N), .wADDR(WA), .wDATA(WD),
    .wCNT(WC), .TW_LEAD(TW), .OVT_LIMIT(OVT)) u_dut (
    .clk(clk), .rst_n(rst_n), .fsm(fsm), .sif(sif),
    .sink_3_4(s34), .twdl_sop_sink(tw), .sink_done(done),
    .frame_err(ferr), .ovf(ovf), .overTime(ot));

  mrd_sink_wr_np #(.P(7), .NBANK(7), .wADDR(WA), .wDATA(WD),
    .wCNT(WC), .TW_LEAD(TW), .OVT_LIMIT(OVT)) u_dut7 (
    .clk(clk), .rst_n(rst_n), .fsm(fsm7), .sif(sif7),
    .sink_3_4(s34_7), .twdl_sop_sink(tw_7), .sink_done(done_7),
    .frame_err(ferr_7), .ovf(ovf_7), .overTime(ot_7));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [255:0] got,
                     input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  // reference model state
  int L = 0;
  int mj = 0;
  bit movf = 0;
  int mot = 0;
  logic [WD-1:0] mem_re [N][256];

  // per-row strobe records
  int cyc, n_tw, at_tw, n_34, at_34, n_dn, at_dn;
  int n_err, n_ovf, n_wr;

  task automatic clr_rec();
    cyc = 0; n_tw = 0; at_tw = -1; n_34 = 0; at_34 = -1;
    n_dn = 0; at_dn = -1; n_err = 0; n_ovf = 0; n_wr = 0;
  endtask

  task automatic tick(input bit v, input bit ramp,
                      input logic [2:0] f);
    logic [N-1:0] ew;
    logic [N-1:0][WA-1:0] ea;
    logic [N-1:0][WD-1:0] er, ei;
    int thr, jc, g;
    bit e34, etw, edn, eerr, eovf, eot;
    sif.frame_len = WC'(L);
    sif.in_valid = v;
    fsm = f;
    for (int k = 0; k < P; k++) begin
      g = P * mj + k;
      sif.in_real[k] = !v ? '0 : ramp ? WD'(g) : WD'($urandom);
      sif.in_imag[k] = !v ? '0 : ramp ? ~WD'(g) : WD'($urandom);
    end
    ew = '0; ea = '0; er = '0; ei = '0;
    thr = L / 4 + L / 2;
    jc = (L != 0 && mj > L) ? L : mj;
    if (v && (L == 0 || mj < L))
      for (int k = 0; k < P; k++) begin
        g = P * mj + k;
        ew[g % N] = 1'b1;
        ea[g % N] = WA'(g / N);
        er[g % N] = sif.in_real[k];
        ei[g % N] = sif.in_imag[k];
      end
    e34  = v && jc != 0 && jc == thr - 1;
    etw  = v && thr > TW && jc == thr - TW;
    edn  = v && L != 0 && jc == L - 1;
    eerr = !v && L != 0 && mj > 0 && mj < L;
    eovf = v && (movf || (L != 0 && mj >= L));
    mot  = (f == SINK) ? ((mot < OVT) ? mot + 1 : mot) : 0;
    eot  = (mot >= OVT);
    movf = eovf;
    mj   = v ? mj + 1 : 0;
    @(posedge clk); #1;
    chk("wren", sif.wren, ew);
    chk("wraddr", sif.wraddr, ea);
    chk("din", {sif.din_real, sif.din_imag}, {er, ei});
    chk("strobes", {s34, tw, done, ferr, ovf, ot},
        {e34, etw, edn, eerr, eovf, eot});
    for (int b = 0; b < N; b++)
      if (sif.wren[b]) mem_re[b][sif.wraddr[b]] = sif.din_real[b];
    if (tw)   begin n_tw++; at_tw = cyc; end
    if (s34)  begin n_34++; at_34 = cyc; end
    if (done) begin n_dn++; at_dn = cyc; end
    if (ferr) n_err++;
    if (ovf)  n_ovf++;
    n_wr += $countones(sif.wren);
    cyc++;
  endtask

  typedef struct {
    int len; int nb; int tw_at; int s34_at; int dn_at;
    int err_n; int ovf_n; int wr_n;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{12, 12,  6,  8, 11, 0, 0, 48};
    tbl[1] = '{12,  5, -1, -1, -1, 1, 0, 20};
    tbl[2] = '{12, 14,  6,  8, 11, 0, 2, 48};
    tbl[3] = '{ 4,  4, -1,  2,  3, 0, 0, 16};
    tbl[4] = '{ 8,  8,  3,  5,  7, 0, 0, 32};
    tbl[5] = '{ 5,  3, -1,  2, -1, 1, 0, 12};
    tbl[6] = '{ 1,  1, -1, -1,  0, 0, 0,  4};
    tbl[7] = '{ 2,  2, -1, -1,  1, 0, 0,  8};

    sif.frame_len = '0; sif.in_valid = 1'b0;
    sif.in_real = '0; sif.in_imag = '0;
    sif7.frame_len = WC'(12); sif7.in_valid = 1'b0;
    sif7.in_real = '0; sif7.in_imag = '0;
    fsm = IDLE; fsm7 = IDLE;
    #12;
    chk("rst_wren", {sif.wren, sif7.wren}, '0);
    chk("rst_addr", {sif.wraddr, sif7.wraddr}, '0);
    chk("rst_data", {sif.din_real, sif.din_imag}, '0);
    chk("rst_strb", {s34, tw, done, ferr, ovf, ot}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ramp frame, then readback of every sample
    L = 12;
    clr_rec();
    for (int j = 0; j < 12; j++) begin
      tick(1'b1, 1'b1, IDLE);
      if (j == 0)
        chk("b0_map", {sif.wren[3:0], sif.wraddr[0], sif.wraddr[3]},
            {4'hf, 8'd0, 8'd0});
      if (j == 1)
        chk("b1_lane3", {sif.wren[0], sif.wraddr[0], sif.din_real[0]},
            {1'b1, 8'd1, 16'd7});
    end
    tick(1'b0, 1'b0, IDLE);
    tick(1'b0, 1'b0, IDLE);
    for (int g = 0; g < 48; g++)
      chk("readback", mem_re[g % N][g / N], WD'(g));

    // strobe table
    for (int r = 0; r < 8; r++) begin
      L = tbl[r].len;
      clr_rec();
      for (int i = 0; i < tbl[r].nb; i++) tick(1'b1, 1'b0, IDLE);
      for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, IDLE);
      chk("t_tw_n", n_tw, (tbl[r].tw_at >= 0) ? 1 : 0);
      chk("t_tw_at", at_tw, tbl[r].tw_at);
      chk("t_34_n", n_34, (tbl[r].s34_at >= 0) ? 1 : 0);
      chk("t_34_at", at_34, tbl[r].s34_at);
      chk("t_dn_n", n_dn, (tbl[r].dn_at >= 0) ? 1 : 0);
      chk("t_dn_at", at_dn, tbl[r].dn_at);
      chk("t_err", n_err, tbl[r].err_n);
      chk("t_ovf", n_ovf, tbl[r].ovf_n);
      chk("t_wr", n_wr, tbl[r].wr_n);
    end

    // short burst then restart at bank 0 address 0
    L = 12;
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, IDLE);
    tick(1'b0, 1'b0, IDLE);
    tick(1'b1, 1'b0, IDLE);
    chk("restart", {sif.wren[0], sif.wraddr[0]}, {1'b1, 8'd0});
    tick(1'b0, 1'b0, IDLE);

    // overtime
    begin
      int first;
      first = -1;
      for (int i = 1; i <= 3000; i++) begin
        tick(1'b0, 1'b0, SINK);
        if (ot && first < 0) first = i;
      end
      chk("ovt_rise", first, 2047);
      chk("ovt_hold", ot, 1'b1);
      tick(1'b0, 1'b0, IDLE);
      chk("ovt_clr", ot, 1'b0);
    end

    // random bursts
    for (int b = 0; b < 60; b++) begin
      logic [2:0] f;
      int nb;
      L = $urandom_range(1, 20);
      nb = $urandom_range(1, L + 3);
      f = ($urandom_range(0, 1) != 0) ? SINK : IDLE;
      for (int i = 0; i < nb; i++) tick(1'b1, 1'b0, f);
      for (int i = 0; i < $urandom_range(1, 3); i++)
        tick(1'b0, 1'b0, f);
    end
    tick(1'b0, 1'b0, IDLE);

    // P = NBANK: every bank every beat, then async reset mid-burst
    for (int j = 0; j < 6; j++) begin
      logic [6:0][WA-1:0] ea7;
      logic [6:0][WD-1:0] ed7;
      sif7.in_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
        sif7.in_real[k] = WD'($urandom);
        ea7[k] = WA'(j);
        ed7[k] = sif7.in_real[k];
      end
      @(posedge clk); #1;
      chk("p7_wren", sif7.wren, 7'h7f);
      chk("p7_addr", sif7.wraddr, ea7);
      chk("p7_data", sif7.din_real, ed7);
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wren", {sif7.wren, sif.wren}, '0);
    chk("arst_addr", sif7.wraddr, '0);
    chk("arst_data", {sif7.din_real, sif7.din_imag}, '0);
    chk("arst_strb", {s34_7, tw_7, done_7, ferr_7, ovf_7}, '0);
    rst_n = 1'b1;
    mj = 0; movf = 0; mot = 0;
    for (int j = 0; j < 2; j++) begin
      logic [6:0][WA-1:0] ea7;
      for (int k = 0; k < 7; k++) ea7[k] = WA'(j);
      @(posedge clk); #1;
      chk("p7_post_rst", {sif7.wren, sif7.wraddr}, {7'h7f, ea7});
    end
    sif7.in_valid = 1'b0;
    tick(1'b0, 1'b0, IDLE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
